// File: rtl/collatz_sweep_master_pkg.sv
// Shared definitions for the Collatz sweep master: FSM encodings and default sizing.
package collatz_sweep_master_pkg;

  localparam int W_DEF       = 8;
  localparam int TIMEOUT_DEF = 1024;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP     = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_CMP       = 3'd4,
    ST_FIN       = 3'd5
  } state_e;

  // Width of a watchdog counter able to hold values 0..timeout.
  function automatic int wd_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/collatz_sweep_master_if.sv
// Upstream (soc/eoc slave) and downstream (soc_x/eoc_x master) signals of the sweep master.
interface collatz_sweep_master_if #(
  parameter int W = 8
) ();

  logic         soc;
  logic         eoc;
  logic [W-1:0] n_lo;
  logic [W-1:0] n_hi;
  logic [W-1:0] n_max;
  logic [W-1:0] k_max;
  logic         err;
  logic         soc_x;
  logic         eoc_x;
  logic [W-1:0] n_x;
  logic [W-1:0] k_x;

  // The sweep master itself.
  modport master (
    input  soc, n_lo, n_hi, eoc_x, k_x,
    output eoc, n_max, k_max, err, soc_x, n_x
  );

  // Its environment: upstream requester plus downstream Collatz unit.
  modport slave (
    output soc, n_lo, n_hi, eoc_x, k_x,
    input  eoc, n_max, k_max, err, soc_x, n_x
  );

endinterface

// File: rtl/collatz_sweep_master_initiator.sv
// soc_x/eoc_x initiator: SETUP -> WAIT_ACK -> WAIT_DONE for one operand, with a watchdog.
module soc_eoc_initiator
  import collatz_sweep_master_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clock,
  input  logic reset_,
  input  logic go_i,
  input  logic eoc_x_i,
  output logic soc_x_o,
  output logic done_o,
  output logic timeout_o
);

  localparam int              CNT_W   = wd_width(TIMEOUT);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             soc_x_q, soc_x_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic             waiting_s;
  logic             expired_s;

  assign waiting_s = ((state_q == ST_WAIT_ACK) && eoc_x_i) ||
                     ((state_q == ST_WAIT_DONE) && !eoc_x_i);
  assign expired_s = (wd_q == WD_LAST);
  assign done_o    = (state_q == ST_WAIT_DONE) && eoc_x_i;
  assign timeout_o = waiting_s && expired_s;
  assign soc_x_o   = soc_x_q;

  // State, soc_x and watchdog registers.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q <= ST_IDLE;
      soc_x_q <= 1'b0;
      wd_q    <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      soc_x_q <= soc_x_d;
      wd_q    <= wd_d;
    end
  end

  // Next-state: SETUP refuses to start while the slave still reports busy.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (go_i)          state_d = ST_SETUP;     else state_d = ST_IDLE;
      ST_SETUP:     if (eoc_x_i)       state_d = ST_WAIT_ACK;  else state_d = ST_SETUP;
      ST_WAIT_ACK:  if (!eoc_x_i)      state_d = ST_WAIT_DONE;
                    else if (expired_s) state_d = ST_IDLE;
                    else               state_d = ST_WAIT_ACK;
      ST_WAIT_DONE: if (eoc_x_i)       state_d = ST_IDLE;
                    else if (expired_s) state_d = ST_IDLE;
                    else               state_d = ST_WAIT_DONE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  // soc_x is high exactly while waiting for the acknowledge; the watchdog restarts on each wait state entry.
  always_comb begin
    soc_x_d = (state_d == ST_WAIT_ACK);
    if (state_d != state_q) begin
      wd_d = {CNT_W{1'b0}};
    end else if (waiting_s) begin
      wd_d = wd_q + CNT_W'(1);
    end else begin
      wd_d = {CNT_W{1'b0}};
    end
  end

endmodule

// File: rtl/collatz_sweep_master.sv
// Sweeps n over [n_lo, n_hi] through a downstream Collatz unit and reports the n with the largest step count.
module collatz_sweep_master
  import collatz_sweep_master_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic                     clock,
  input logic                     reset_,
  collatz_sweep_master_if.master  bus
);

  state_e       state_q, state_d;
  logic         eoc_q, eoc_d;
  logic         err_q, err_d;
  logic [W-1:0] n_x_q, n_x_d;
  logic [W-1:0] n_hi_q, n_hi_d;
  logic [W-1:0] n_max_q, n_max_d;
  logic [W-1:0] k_max_q, k_max_d;
  logic [W-1:0] k_cap_q, k_cap_d;
  logic         go_s;
  logic         done_s;
  logic         timeout_s;
  logic         soc_x_s;
  logic         bad_range_s;

  assign bad_range_s = (bus.n_lo == {W{1'b0}}) || (bus.n_lo > bus.n_hi);

  soc_eoc_initiator #(
    .TIMEOUT (TIMEOUT)
  ) u_initiator (
    .clock     (clock),
    .reset_    (reset_),
    .go_i      (go_s),
    .eoc_x_i   (bus.eoc_x),
    .soc_x_o   (soc_x_s),
    .done_o    (done_s),
    .timeout_o (timeout_s)
  );

  assign bus.eoc   = eoc_q;
  assign bus.err   = err_q;
  assign bus.n_x   = n_x_q;
  assign bus.n_max = n_max_q;
  assign bus.k_max = k_max_q;
  assign bus.soc_x = soc_x_s;

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q <= ST_IDLE;
      eoc_q   <= 1'b1;
      err_q   <= 1'b0;
      n_x_q   <= {W{1'b0}};
      n_hi_q  <= {W{1'b0}};
      n_max_q <= {W{1'b0}};
      k_max_q <= {W{1'b0}};
      k_cap_q <= {W{1'b0}};
    end else begin
      state_q <= state_d;
      eoc_q   <= eoc_d;
      err_q   <= err_d;
      n_x_q   <= n_x_d;
      n_hi_q  <= n_hi_d;
      n_max_q <= n_max_d;
      k_max_q <= k_max_d;
      k_cap_q <= k_cap_d;
    end
  end

  // Next-state: here SETUP covers the whole downstream exchange run by the initiator.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.soc) state_d = bad_range_s ? ST_FIN : ST_SETUP;
        else         state_d = ST_IDLE;
      end
      ST_SETUP: begin
        if (timeout_s)   state_d = ST_FIN;
        else if (done_s) state_d = ST_CMP;
        else             state_d = ST_SETUP;
      end
      ST_CMP: begin
        if (n_x_q == n_hi_q) state_d = ST_FIN;
        else                 state_d = ST_SETUP;
      end
      ST_FIN: begin
        if (!bus.soc) state_d = ST_IDLE;
        else          state_d = ST_FIN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values and the go strobe that launches the initiator.
  always_comb begin
    eoc_d   = eoc_q;
    err_d   = err_q;
    n_x_d   = n_x_q;
    n_hi_d  = n_hi_q;
    n_max_d = n_max_q;
    k_max_d = k_max_q;
    k_cap_d = k_cap_q;
    go_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.soc) begin
          eoc_d   = 1'b0;
          err_d   = bad_range_s;
          k_max_d = {W{1'b0}};
          n_max_d = bus.n_lo;
          n_hi_d  = bus.n_hi;
          if (!bad_range_s) begin
            n_x_d = bus.n_lo;
            go_s  = 1'b1;
          end else begin
            n_x_d = n_x_q;
          end
        end else begin
          eoc_d = 1'b1;
        end
      end
      ST_SETUP: begin
        if (timeout_s)   err_d   = 1'b1;
        else if (done_s) k_cap_d = bus.k_x;
        else             k_cap_d = k_cap_q;
      end
      ST_CMP: begin
        // Strict compare: on a tie the earlier, smaller n is kept.
        if (k_cap_q > k_max_q) begin
          k_max_d = k_cap_q;
          n_max_d = n_x_q;
        end else begin
          k_max_d = k_max_q;
        end
        // Equality test before increment, so n_hi at the top of the range never wraps n_x.
        if (n_x_q != n_hi_q) begin
          n_x_d = n_x_q + {{(W-1){1'b0}}, 1'b1};
          go_s  = 1'b1;
        end else begin
          n_x_d = n_x_q;
        end
      end
      ST_FIN: begin
        if (!bus.soc) eoc_d = 1'b1;
        else          eoc_d = 1'b0;
      end
      default: begin
        eoc_d = 1'b1;
      end
    endcase
  end

endmodule
